// File: rtl/lsu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Purpose  : Single-outstanding load/store sequencer with lane formatting.
//            Optional bus timeout enabled by defining LSU_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_req_i,
  input  logic        ex_wr_i,
  input  logic [1:0]  ex_byte_i,
  input  logic        ex_zero_extnd_i,
  input  logic [31:0] ex_addr_i,
  input  logic [31:0] ex_wdata_i,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        mem_req_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        ld_valid_o,
  output logic [31:0] ld_data_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e      state_q;
  logic        wr_q;
  logic [3:0]  be_q;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        zext_q;

  logic [1:0]  size_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic        misal;
  logic        accept;
  logic        rsp_done;
  logic        timeout;
  logic [15:0] lane;
  logic [31:0] ld_fmt;

  // Encoding 11 behaves as a full word.
  assign size_d = (ex_byte_i == 2'b11) ? SZ_WORD : ex_byte_i;

  assign misal  = ((size_d == SZ_HALF) && ex_addr_i[0]) ||
                  ((size_d == SZ_WORD) && (ex_addr_i[1:0] != 2'b00));
  assign accept = (state_q == S_IDLE) && ex_req_i && !misal;
  assign rsp_done = (state_q == S_WAIT) && mem_rvalid_i;

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = ex_wdata_i;
    case (size_d)
      SZ_BYTE: begin
        be_d    = 4'b0001 << ex_addr_i[1:0];
        wdata_d = {4{ex_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_d    = ex_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{ex_wdata_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = ex_wdata_i;
      end
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] tmo_cnt_q;

  // A response arriving in the expiry cycle still completes normally.
  assign timeout = (state_q != S_IDLE) && !rsp_done &&
                   (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else if (accept) begin
      tmo_cnt_q <= '0;
    end else if (state_q != S_IDLE) begin
      tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      be_q    <= 4'b0;
      addr_q  <= 30'b0;
      wdata_q <= 32'b0;
      off_q   <= 2'b0;
      size_q  <= 2'b0;
      zext_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q <= S_REQ;
            wr_q    <= ex_wr_i;
            be_q    <= be_d;
            addr_q  <= ex_addr_i[31:2];
            wdata_q <= wdata_d;
            off_q   <= ex_addr_i[1:0];
            size_q  <= size_d;
            zext_q  <= ex_zero_extnd_i;
          end
        end
        S_REQ: begin
          if (timeout) begin
            state_q <= S_IDLE;
          end else if (mem_gnt_i) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i || timeout) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign lane = 16'(mem_rdata_i >> {off_q, 3'b000});

  always_comb begin
    ld_fmt = mem_rdata_i;
    case (size_q)
      SZ_BYTE: ld_fmt = zext_q ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      SZ_HALF: ld_fmt = zext_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ld_fmt = mem_rdata_i;
    endcase
  end

  // ex_* may be live while reset is held; gate the decode-driven outputs.
  assign stall_o      = !reset && (accept ||
                                   ((state_q == S_REQ)  && !timeout) ||
                                   ((state_q == S_WAIT) && !mem_rvalid_i && !timeout));
  assign misaligned_o = !reset && (state_q == S_IDLE) && ex_req_i && misal;

  assign mem_req_o   = (state_q == S_REQ) && !timeout;
  assign mem_wr_o    = wr_q;
  assign mem_addr_o  = {addr_q, 2'b00};
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;

  assign ld_valid_o = rsp_done && !wr_q;
  assign ld_data_o  = ld_valid_o ? ld_fmt : 32'b0;
  assign bus_err_o  = timeout;

endmodule
`default_nettype wire
